// File: rtl/snn_step_ctrl.sv
// Purpose: per-sample timestep scheduler for one SNN sub-array (init, count clear, synapse/STDP passes).
// Latency: i_start to first o_syn_run is INIT_CYC+2 cycles; all outputs are registered (Moore).
// Backpressure: none; each pass waits for its done pulse, guarded by a watchdog that aborts to IDLE.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i_start / i_abort           begin a sample (IDLE only) / force IDLE (highest priority)
//   i_lern, i_num_steps         mode and timestep count, both captured on an accepted i_start
//   i_syn_done, i_stdp_done     pass-complete pulses, honoured only in the matching wait state
//   o_init, o_cnt_clr           init level, post-spike counter clear pulse
//   o_syn_run, o_stdp_run       pass start pulses; o_sub selects potentiation(0)/depression(1)
//   o_s_stdp                    weight-BRAM port-0 owner (1 = STDP)
//   o_s_lern, o_s_infr          mode flags to the neuron array, both 0 in IDLE
//   o_step_idx                  current timestep (0-based)
//   o_busy, o_done, o_timeout   status: not IDLE, sample-complete pulse, sticky watchdog flag
module snn_step_ctrl #(
  parameter int STEP_W   = 8,
  parameter int INIT_CYC = 32,
  parameter int TO_W     = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_lern,
  input  logic [STEP_W-1:0] i_num_steps,
  input  logic              i_syn_done,
  input  logic              i_stdp_done,
  output logic              o_init,
  output logic              o_cnt_clr,
  output logic              o_syn_run,
  output logic              o_stdp_run,
  output logic              o_sub,
  output logic              o_s_stdp,
  output logic              o_s_lern,
  output logic              o_s_infr,
  output logic [STEP_W-1:0] o_step_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_CLR, S_SRUN, S_SWAIT, S_PRUN, S_PWAIT,
    S_DRUN, S_DWAIT, S_NEXT, S_FIN
  } state_t;

  localparam int ICW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [ICW-1:0]  INIT_LAST = ICW'(INIT_CYC - 1);
  // Last permitted wait-cycle count: the wait state is occupied 2**TO_W-1 cycles before expiry.
  localparam logic [TO_W-1:0] WD_LAST   = {{(TO_W-1){1'b1}}, 1'b0};

  state_t state_q, state_d;

  logic [ICW-1:0]    init_cnt;
  logic [TO_W-1:0]   wd_cnt;
  logic [STEP_W-1:0] last_idx;
  logic              lern_q;
  logic              start_ok;
  logic              in_wait;
  logic              wd_exp;
  logic              wd_fire;
  logic              last_step;

  // Output decode of the next state, registered so every output comes straight from a flop.
  logic init_d, cnt_clr_d, syn_run_d, stdp_run_d, sub_d, s_stdp_d, busy_d, done_d, lern_d;

  assign start_ok  = i_start & ~i_abort & (state_q == S_IDLE);
  assign in_wait   = (state_q == S_SWAIT) | (state_q == S_PWAIT) | (state_q == S_DWAIT);
  assign wd_exp    = (wd_cnt == WD_LAST);
  assign last_step = (o_step_idx == last_idx);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    wd_fire = 1'b0;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (i_start) state_d = S_INIT;
        S_INIT:  if (init_cnt == INIT_LAST) state_d = S_CLR;
        S_CLR:   state_d = S_SRUN;
        S_SRUN:  state_d = S_SWAIT;
        S_SWAIT: begin
          if (i_syn_done) begin
            state_d = lern_q ? S_PRUN : S_NEXT;
          end else if (wd_exp) begin
            state_d = S_IDLE;
            wd_fire = 1'b1;
          end
        end
        S_PRUN:  state_d = S_PWAIT;
        S_PWAIT: begin
          if (i_stdp_done) begin
            state_d = S_DRUN;
          end else if (wd_exp) begin
            state_d = S_IDLE;
            wd_fire = 1'b1;
          end
        end
        S_DRUN:  state_d = S_DWAIT;
        S_DWAIT: begin
          if (i_stdp_done) begin
            state_d = S_NEXT;
          end else if (wd_exp) begin
            state_d = S_IDLE;
            wd_fire = 1'b1;
          end
        end
        S_NEXT:  state_d = last_step ? S_FIN : S_SRUN;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- output decode
  always_comb begin
    init_d     = (state_d == S_INIT);
    cnt_clr_d  = (state_d == S_CLR);
    syn_run_d  = (state_d == S_SRUN);
    stdp_run_d = (state_d == S_PRUN) | (state_d == S_DRUN);
    sub_d      = (state_d == S_DRUN) | (state_d == S_DWAIT);
    s_stdp_d   = (state_d == S_PRUN) | (state_d == S_PWAIT) |
                 (state_d == S_DRUN) | (state_d == S_DWAIT);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    lern_d     = start_ok ? i_lern : lern_q;
  end

  // ---------------------------------------------------------------- counters, latches, outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt   <= '0;
      wd_cnt     <= '0;
      last_idx   <= '0;
      lern_q     <= 1'b0;
      o_step_idx <= '0;
      o_timeout  <= 1'b0;
      o_init     <= 1'b0;
      o_cnt_clr  <= 1'b0;
      o_syn_run  <= 1'b0;
      o_stdp_run <= 1'b0;
      o_sub      <= 1'b0;
      o_s_stdp   <= 1'b0;
      o_s_lern   <= 1'b0;
      o_s_infr   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      // Counts from 0 on the first INIT cycle since it idles at 0 everywhere else.
      init_cnt <= (state_q == S_INIT) ? init_cnt + 1'b1 : '0;
      // Wait states are only entered from run states, so clearing outside them restarts per wait.
      wd_cnt   <= in_wait ? wd_cnt + 1'b1 : '0;

      if (start_ok) begin
        lern_q   <= i_lern;
        // A zero step count runs a single timestep.
        last_idx <= (i_num_steps == '0) ? '0 : i_num_steps - 1'b1;
      end

      if (state_d == S_IDLE) begin
        o_step_idx <= '0;
      end else if (state_q == S_NEXT && !last_step) begin
        o_step_idx <= o_step_idx + 1'b1;
      end

      if (start_ok) begin
        o_timeout <= 1'b0;
      end else if (wd_fire) begin
        o_timeout <= 1'b1;
      end

      o_init     <= init_d;
      o_cnt_clr  <= cnt_clr_d;
      o_syn_run  <= syn_run_d;
      o_stdp_run <= stdp_run_d;
      o_sub      <= sub_d;
      o_s_stdp   <= s_stdp_d;
      o_s_lern   <= busy_d &  lern_d;
      o_s_infr   <= busy_d & ~lern_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

endmodule
